// File: rtl/btc_pkg.sv
// Shared types and constants for the bitcoin nonce search path (nonce_gen / nonce_check).
package btc_pkg;

   localparam int HASH_W  = 256;
   localparam int NONCE_W = 32;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      RUN       = 3'd2,
      FOUND     = 3'd3,
      EXHAUSTED = 3'd4
   } state_t;

   // SHA256 padding of the 80-byte header's second block: 0x80 marker, zeros, 640-bit length.
   localparam logic [383:0] BLOCK2_PAD = {32'h8000_0000, 320'h0, 32'h0000_0280};

   function automatic logic [255:0] byte_reverse256(input logic [255:0] d);
      logic [255:0] r;
      for (int i = 0; i < 32; i++) begin
         r[8*i +: 8] = d[8*(31-i) +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/nbits_expand.sv
// Combinational decoder from compact nBits (exp[31:24], sign[23], mant[22:0]) to a 256-bit target.
module nbits_expand
   import btc_pkg::*;
(
   input  logic [31:0]       nbits,
   output logic [HASH_W-1:0] target
);

   logic [7:0]        exp_s;
   logic [23:0]       mant_s;
   logic [HASH_W-1:0] wide_s;

   // Shift the mantissa by whole bytes; bits pushed past the top are simply lost.
   always_comb begin
      exp_s  = nbits[31:24];
      mant_s = nbits[23] ? 24'd0 : {1'b0, nbits[22:0]};
      wide_s = {{(HASH_W-24){1'b0}}, mant_s};
      if (exp_s < 8'd3) begin
         target = wide_s >> {(8'd3 - exp_s), 3'b000};
      end else begin
         target = wide_s << {(exp_s - 8'd3), 3'b000};
      end
   end

endmodule

// File: rtl/nonce_check.sv
// Digest-vs-target checker closing the nonce_gen handshake; latches the winning nonce.
// Optional feature: define HASH_COUNT_EN to add a saturating 64-bit hash_count output.
module nonce_check
   import btc_pkg::*;
#(
   parameter logic [NONCE_W-1:0] NONCE_LAST = 32'hFFFF_FFFF
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [31:0]        nbits,
   input  logic               hash_valid,
   input  logic [HASH_W-1:0]  hash_in,
   input  logic [NONCE_W-1:0] hash_nonce,
   output logic               done,
   output logic               end_nonce,
   output logic               found,
   output logic [NONCE_W-1:0] nonce_accepted,
   output logic               busy
`ifdef HASH_COUNT_EN
   ,
   output logic [63:0]        hash_count
`endif
);

   state_t             state, state_next;
   logic [31:0]        nbits_r;
   logic [HASH_W-1:0]  target_r;
   logic [HASH_W-1:0]  target_s;
   logic [HASH_W-1:0]  rev_r;
   logic [NONCE_W-1:0] s1_nonce_r;
   logic               s1_valid_r;
   logic               hit_s;
   logic               last_miss_s;
   logic               accept_s;

   nbits_expand u_expand (
      .nbits  (nbits_r),
      .target (target_s)
   );

   // Stage-2 compare and S1 admission; nothing enters S1 on the edge the search ends.
   always_comb begin
      hit_s       = 1'b0;
      last_miss_s = 1'b0;
      if (state == RUN && s1_valid_r) begin
         hit_s       = (rev_r <= target_r);
         last_miss_s = !(rev_r <= target_r) && (s1_nonce_r == NONCE_LAST);
      end else begin
         hit_s       = 1'b0;
         last_miss_s = 1'b0;
      end
      accept_s = (state == RUN) && hash_valid && !start && !hit_s && !last_miss_s;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; start restarts the search from any state.
   always_comb begin
      state_next = state;
      if (start) begin
         state_next = LOAD;
      end else begin
         case (state)
            IDLE:      state_next = IDLE;
            LOAD:      state_next = RUN;
            RUN: begin
               if (hit_s) begin
                  state_next = FOUND;
               end else if (last_miss_s) begin
                  state_next = EXHAUSTED;
               end else begin
                  state_next = RUN;
               end
            end
            FOUND:     state_next = FOUND;
            EXHAUSTED: state_next = EXHAUSTED;
            default:   state_next = IDLE;
         endcase
      end
   end

   // Status outputs decoded straight from the state register.
   always_comb begin
      busy      = 1'b0;
      found     = 1'b0;
      end_nonce = 1'b0;
      case (state)
         LOAD, RUN: busy = 1'b1;
         FOUND: begin
            found     = 1'b1;
            end_nonce = 1'b1;
         end
         EXHAUSTED: end_nonce = 1'b1;
         default: begin
            busy      = 1'b0;
            found     = 1'b0;
            end_nonce = 1'b0;
         end
      endcase
   end

   // Target load, S1 pipeline, done pulse and winner latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         nbits_r        <= 32'd0;
         target_r       <= {HASH_W{1'b0}};
         rev_r          <= {HASH_W{1'b0}};
         s1_nonce_r     <= {NONCE_W{1'b0}};
         s1_valid_r     <= 1'b0;
         done           <= 1'b0;
         nonce_accepted <= {NONCE_W{1'b0}};
      end else begin
         done       <= accept_s;
         s1_valid_r <= accept_s;
         if (accept_s) begin
            rev_r      <= byte_reverse256(hash_in);
            s1_nonce_r <= hash_nonce;
         end
         if (start) begin
            nbits_r <= nbits;
         end
         if (state == LOAD) begin
            target_r <= target_s;
         end
         if (start) begin
            nonce_accepted <= {NONCE_W{1'b0}};
         end else if (hit_s) begin
            nonce_accepted <= s1_nonce_r;
         end
      end
   end

`ifdef HASH_COUNT_EN
   // Digests admitted into S1 since the last start, saturating.
   always_ff @(posedge clk) begin
      if (rst || start) begin
         hash_count <= 64'd0;
      end else if (accept_s && (hash_count != {64{1'b1}})) begin
         hash_count <= hash_count + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_nonce_check.sv
// Directed bench for nonce_check: single-digest vector table plus multi-cycle corner sequences.
module tb_nonce_check;

   logic         clk = 1'b0;
   logic         rst, start, hash_valid;
   logic [31:0]  nbits;
   logic [255:0] hash_in;
   logic [31:0]  hash_nonce;

   logic         done, end_nonce, found, busy;
   logic [31:0]  nonce_accepted;
   logic         l3_done, l3_end_nonce, l3_found, l3_busy;
   logic [31:0]  l3_nonce_accepted;
`ifdef HASH_COUNT_EN
   logic [63:0]  hash_count, l3_hash_count;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   nonce_check dut (
      .clk(clk), .rst(rst), .start(start), .nbits(nbits),
      .hash_valid(hash_valid), .hash_in(hash_in), .hash_nonce(hash_nonce),
      .done(done), .end_nonce(end_nonce), .found(found),
      .nonce_accepted(nonce_accepted), .busy(busy)
`ifdef HASH_COUNT_EN
      , .hash_count(hash_count)
`endif
   );

   nonce_check #(.NONCE_LAST(32'd3)) dut_l3 (
      .clk(clk), .rst(rst), .start(start), .nbits(nbits),
      .hash_valid(hash_valid), .hash_in(hash_in), .hash_nonce(hash_nonce),
      .done(l3_done), .end_nonce(l3_end_nonce), .found(l3_found),
      .nonce_accepted(l3_nonce_accepted), .busy(l3_busy)
`ifdef HASH_COUNT_EN
      , .hash_count(l3_hash_count)
`endif
   );

   typedef struct {
      logic [31:0]  nbits;
      logic [255:0] hash;
      logic [31:0]  nonce;
      logic         hit;
   } vec_t;

   vec_t vecs[12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

`ifdef HASH_COUNT_EN
   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask
`endif

   task automatic begin_search(input logic [31:0] nb);
      start = 1'b1;
      nbits = nb;
      tick();
      start = 1'b0;
      tick();
   endtask

   initial begin
      logic [31:0] done_cnt;

      rst = 1'b1; start = 1'b0; hash_valid = 1'b0;
      nbits = 32'd0; hash_in = 256'd0; hash_nonce = 32'd0;

      vecs[0]  = '{32'h207F_FFFF, 256'h0,                                 32'd5,  1'b1};
      vecs[1]  = '{32'h1D00_FFFF, 256'hFFFF_0000_0000,                    32'd7,  1'b1};
      vecs[2]  = '{32'h1D00_FFFF, {8'h01, 200'h0, 48'hFFFF_0000_0000},   32'd8,  1'b0};
      vecs[3]  = '{32'h1D80_FFFF, 256'h0,                                 32'd9,  1'b1};
      vecs[4]  = '{32'h1D80_FFFF, 256'h1,                                 32'd10, 1'b0};
      vecs[5]  = '{32'h207F_FFFF, 256'h80,                                32'd11, 1'b0};
      vecs[6]  = '{32'h207F_FFFF, 256'hFF_FF7F,                           32'd12, 1'b1};
      vecs[7]  = '{32'h0312_3456, {24'h56_3412, 232'h0},                  32'd13, 1'b1};
      vecs[8]  = '{32'h0112_3456, {8'h13, 248'h0},                        32'd14, 1'b0};
      vecs[9]  = '{32'h0112_3456, {8'h12, 248'h0},                        32'd15, 1'b1};
      vecs[10] = '{32'h2212_3456, 256'h57,                                32'd16, 1'b0};
      vecs[11] = '{32'h2212_3456, 256'h56,                                32'd17, 1'b1};

      // Reset values, held and after release.
      tick(); tick();
      chk1("rst_done", done, 1'b0);
      chk1("rst_end", end_nonce, 1'b0);
      chk1("rst_found", found, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk32("rst_nonce", nonce_accepted, 32'd0);
      rst = 1'b0;
      tick();
      chk1("idle_busy", busy, 1'b0);

      // Single-digest vectors: done at N+1, verdict at N+2.
      for (int i = 0; i < 12; i++) begin
         start = 1'b1;
         nbits = vecs[i].nbits;
         tick();
         start = 1'b0;
         chk1($sformatf("v%0d_load_busy", i), busy, 1'b1);
         tick();
         hash_valid = 1'b1;
         hash_in    = vecs[i].hash;
         hash_nonce = vecs[i].nonce;
         tick();
         hash_valid = 1'b0;
         chk1($sformatf("v%0d_done", i), done, 1'b1);
         chk1($sformatf("v%0d_end_early", i), end_nonce, 1'b0);
         tick();
         chk1($sformatf("v%0d_found", i), found, vecs[i].hit);
         chk1($sformatf("v%0d_end", i), end_nonce, vecs[i].hit);
         chk32($sformatf("v%0d_nonce", i), nonce_accepted, vecs[i].hit ? vecs[i].nonce : 32'd0);
         chk1($sformatf("v%0d_done_off", i), done, 1'b0);
      end

      // Hit with a second digest in flight: it is discarded and gives no done.
      begin_search(32'h207F_FFFF);
      hash_valid = 1'b1; hash_in = 256'h0; hash_nonce = 32'd5;
      tick();
      chk1("t1_done", done, 1'b1);
      hash_nonce = 32'd6;
      tick();
      hash_valid = 1'b0;
      chk1("t1_found", found, 1'b1);
      chk1("t1_end", end_nonce, 1'b1);
      chk32("t1_nonce", nonce_accepted, 32'd5);
      chk1("t1_no_done_inflight", done, 1'b0);
      tick();
      chk1("t1_done_hold", done, 1'b0);
      chk32("t1_nonce_hold", nonce_accepted, 32'd5);

      // Ten back-to-back misses.
      begin_search(32'h1D00_FFFF);
      done_cnt = 32'd0;
      for (int k = 0; k < 10; k++) begin
         hash_valid = 1'b1; hash_in = 256'hFF; hash_nonce = k;
         tick();
         if (done) done_cnt++;
      end
      hash_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         if (done) done_cnt++;
      end
      chk32("t2_done_count", done_cnt, 32'd10);
      chk1("t2_found", found, 1'b0);
      chk1("t2_end", end_nonce, 1'b0);
      chk1("t2_busy", busy, 1'b1);
`ifdef HASH_COUNT_EN
      chk64("t2_hash_count", hash_count, 64'd10);
`endif

      // Exhaustion on the short-range instance.
      begin_search(32'h1D00_FFFF);
      for (int k = 0; k < 4; k++) begin
         hash_valid = 1'b1; hash_in = 256'hFF; hash_nonce = k;
         tick();
      end
      hash_valid = 1'b0;
      chk1("t3_end_not_yet", l3_end_nonce, 1'b0);
      tick();
      chk1("t3_end", l3_end_nonce, 1'b1);
      chk1("t3_found", l3_found, 1'b0);
      chk1("t3_busy", l3_busy, 1'b0);
      hash_valid = 1'b1; hash_nonce = 32'd4;
      tick();
      hash_valid = 1'b0;
      chk1("t3_no_done_after_end", l3_done, 1'b0);
      chk1("t3_end_hold", l3_end_nonce, 1'b1);

      // Reset with a hit sitting in S1.
      begin_search(32'h207F_FFFF);
      hash_valid = 1'b1; hash_in = 256'h0; hash_nonce = 32'd11;
      tick();
      hash_nonce = 32'd12;
      rst = 1'b1;
      tick();
      rst = 1'b0; hash_valid = 1'b0;
      chk1("t5_found", found, 1'b0);
      chk1("t5_end", end_nonce, 1'b0);
      chk1("t5_done", done, 1'b0);
      chk1("t5_busy", busy, 1'b0);
      chk32("t5_nonce", nonce_accepted, 32'd0);
      tick();
      chk1("t5_found_later", found, 1'b0);

      // start while FOUND clears the result and re-enters LOAD.
      begin_search(32'h207F_FFFF);
      hash_valid = 1'b1; hash_in = 256'h0; hash_nonce = 32'd13;
      tick();
      hash_valid = 1'b0;
      tick();
      chk32("t5_found_nonce", nonce_accepted, 32'd13);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk1("t5_restart_found", found, 1'b0);
      chk1("t5_restart_end", end_nonce, 1'b0);
      chk32("t5_restart_nonce", nonce_accepted, 32'd0);
      chk1("t5_restart_busy", busy, 1'b1);

      // Sign-set target: start and hash_valid together drop the digest.
      begin_search(32'h1D80_FFFF);
      start = 1'b1; hash_valid = 1'b1; hash_in = 256'h0; hash_nonce = 32'd21;
      tick();
      start = 1'b0; hash_valid = 1'b0;
      chk1("t6_dropped_done", done, 1'b0);
      chk1("t6_load_busy", busy, 1'b1);
      tick();
      tick();
      chk1("t6_found", found, 1'b0);
      chk1("t6_done", done, 1'b0);
`ifdef HASH_COUNT_EN
      chk64("t6_hash_count", hash_count, 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
